// File: rtl/rtc_time_setter_pkg.sv
// rtc_time_setter_pkg
//   Shared definitions for the time-setting front end: FSM state encoding,
//   BCD digit limits, blank-mask bit positions and the mod-60 BCD increment.
package rtc_time_setter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EDIT_MIN,
        EDIT_SEC,
        COMMIT
    } state_t;

    localparam logic [3:0] LOW_MAX  = 4'd9;
    localparam logic [3:0] HIGH_MAX = 4'd5;

    // blank mask layout is {mh, ml, sh, sl}
    localparam int unsigned BLANK_SL = 0;
    localparam int unsigned BLANK_SH = 1;
    localparam int unsigned BLANK_ML = 2;
    localparam int unsigned BLANK_MH = 3;

    // {high, low} BCD field, counts 00..59 and wraps 59 -> 00
    function automatic logic [7:0] bcd_inc60(input logic [7:0] field);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = field[7:4];
        lo = field[3:0];
        if (lo == LOW_MAX) begin
            lo = '0;
            hi = (hi == HIGH_MAX) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/rtc_time_setter_key_debounce.sv
// key_debounce
//   Synchronises one asynchronous raw key, debounces it and emits a one-cycle
//   pulse when the accepted level rises. Releases produce no pulse.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   raw    in   raw key level, active-high, asynchronous
//   press  out  one-cycle press pulse (registered)
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive synced samples that disagree with the accepted
    // level; any sample agreeing with the level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync[1];
                press <= sync[1];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_time_setter.sv
// rtc_time_setter
//   Three-key editor for a minutes:seconds preset. mode enters/commits edit,
//   sel toggles the edited field, inc advances it mod 60. Commit pulses load
//   for one cycle. The edited field blinks through the blank mask.
// Ports:
//   CLOCK2_50          in   clock
//   reset              in   asynchronous active-high reset
//   key_mode/sel/inc   in   raw keys, active-high, asynchronous
//   ml, mh, sl, sh     out  edited BCD digits
//   load               out  one-cycle preset strobe
//   editing            out  high in EDIT_MIN / EDIT_SEC
//   blank              out  per-digit blank {mh, ml, sh, sl}, 1 = dark
module rtc_time_setter
    import rtc_time_setter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_CYCLES    = 12_500_000
) (
    input  logic       CLOCK2_50,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_inc,
    output logic [3:0] ml,
    output logic [3:0] mh,
    output logic [3:0] sl,
    output logic [3:0] sh,
    output logic       load,
    output logic       editing,
    output logic [3:0] blank
);

    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

    logic               mode_ev;
    logic               sel_ev;
    logic               inc_ev;
    state_t             state;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(CLOCK2_50), .rst(reset), .raw(key_mode), .press(mode_ev)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk(CLOCK2_50), .rst(reset), .raw(key_sel), .press(sel_ev)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(CLOCK2_50), .rst(reset), .raw(key_inc), .press(inc_ev)
    );

    // Priority mode > sel > inc: the if/else chain discards the losers.
    always_ff @(posedge CLOCK2_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ml        <= '0;
            mh        <= '0;
            sl        <= '0;
            sh        <= '0;
            load      <= 1'b0;
            editing   <= 1'b0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                IDLE: begin
                    blink_cnt <= '0;
                    phase     <= 1'b0;
                    if (mode_ev) begin
                        state   <= EDIT_MIN;
                        editing <= 1'b1;
                    end
                end
                EDIT_MIN, EDIT_SEC: begin
                    if (mode_ev) begin
                        state     <= COMMIT;
                        load      <= 1'b1;
                        editing   <= 1'b0;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                    end else if (sel_ev) begin
                        state     <= (state == EDIT_MIN) ? EDIT_SEC : EDIT_MIN;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                    end else if (inc_ev) begin
                        if (state == EDIT_MIN) begin
                            {mh, ml} <= bcd_inc60({mh, ml});
                        end else begin
                            {sh, sl} <= bcd_inc60({sh, sl});
                        end
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                    end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
                        blink_cnt <= '0;
                        phase     <= ~phase;
                    end else begin
                        blink_cnt <= blink_cnt + BLINK_W'(1);
                    end
                end
                COMMIT: begin
                    state     <= IDLE;
                    blink_cnt <= '0;
                    phase     <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    editing <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        blank = '0;
        if (phase) begin
            case (state)
                EDIT_MIN: begin
                    blank[BLANK_MH] = 1'b1;
                    blank[BLANK_ML] = 1'b1;
                end
                EDIT_SEC: begin
                    blank[BLANK_SH] = 1'b1;
                    blank[BLANK_SL] = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_time_setter.sv
// tb_rtc_time_setter
//   Self-checking bench: a small behavioural model predicts digits, editing
//   and blank; expected load contents and post-press digit snapshots go
//   through queues and are compared when the DUT produces them.
module tb_rtc_time_setter;

    localparam int unsigned DEB   = 4;
    localparam int unsigned BLINK = 8;
    localparam int          EV_AT = DEB + 3;   // negedge index where an event's effect is visible

    logic       clk = 1'b0;
    logic       rst;
    logic       key_mode;
    logic       key_sel;
    logic       key_inc;
    logic [3:0] ml, mh, sl, sh;
    logic       load;
    logic       editing;
    logic [3:0] blank;

    always #5 clk = ~clk;

    rtc_time_setter #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES(BLINK)
    ) dut (
        .CLOCK2_50(clk),
        .reset(rst),
        .key_mode(key_mode),
        .key_sel(key_sel),
        .key_inc(key_inc),
        .ml(ml),
        .mh(mh),
        .sl(sl),
        .sh(sh),
        .load(load),
        .editing(editing),
        .blank(blank)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] load_q[$];
    logic [15:0] snap_q[$];

    // model: m_state 0 = idle, 1 = edit minutes, 2 = edit seconds
    int         m_state;
    logic [7:0] m_min;
    logic [7:0] m_sec;
    int         age;      // edges since the last blink clear while editing
    logic       load_prev;
    int         fc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] digits();
        return {mh, ml, sh, sl};
    endfunction

    function automatic logic [7:0] inc60(input logic [7:0] v);
        int n;
        n = int'(v[7:4]) * 10 + int'(v[3:0]);
        n = (n + 1) % 60;
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [3:0] m_blank();
        if (m_state == 0 || ((age / BLINK) % 2) == 0) return 4'b0000;
        return (m_state == 1) ? 4'b1100 : 4'b0011;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_min   = '0;
        m_sec   = '0;
        age     = 0;
    endtask

    // ev bits: {mode, sel, inc}
    task automatic apply_event(input logic [2:0] ev);
        if (ev[2]) begin
            if (m_state == 0) begin
                m_state = 1;
            end else begin
                load_q.push_back({m_min, m_sec});
                m_state = 0;
            end
            age = 0;
        end else if (ev[1]) begin
            if (m_state != 0) begin
                m_state = (m_state == 1) ? 2 : 1;
                age = 0;
            end
        end else if (ev[0]) begin
            if (m_state == 1) begin
                m_min = inc60(m_min);
                age = 0;
            end else if (m_state == 2) begin
                m_sec = inc60(m_sec);
                age = 0;
            end
        end
    endtask

    task automatic step(input logic [2:0] ev);
        @(negedge clk);
        if (ev != 3'b000) apply_event(ev);
        else if (m_state != 0) age++;
        check("editing", editing, (m_state != 0));
        check("blank", blank, m_blank());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000);
    endtask

    // hold keys for 'hold' cycles, then release for 'gap' cycles
    task automatic press(input logic [2:0] keys, input int hold, input int gap, output int first_change);
        logic [15:0] start;
        start = digits();
        first_change = 0;
        {key_mode, key_sel, key_inc} = keys;
        for (int n = 1; n <= hold + gap; n++) begin
            step((n == EV_AT && hold >= int'(DEB)) ? keys : 3'b000);
            if (n == EV_AT) snap_q.push_back({m_min, m_sec});
            if (first_change == 0 && digits() != start) first_change = n;
            if (n == hold) {key_mode, key_sel, key_inc} = 3'b000;
        end
        check("digits", digits(), snap_q.pop_front());
    endtask

    task automatic tap(input logic [2:0] keys);
        int d;
        press(keys, 6, 8, d);
    endtask

    // load monitor: width and contents against the load queue
    initial begin
        load_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (load) begin
                check("load_width", load_prev, 1'b0);
                if (load_q.size() == 0) check("load_unexpected", load, 1'b0);
                else check("load_digits", digits(), load_q.pop_front());
            end
            load_prev = load;
        end
    end

    initial begin
        rst = 1'b1;
        {key_mode, key_sel, key_inc} = 3'b000;
        model_reset();
        idle(3);
        check("rst_digits", digits(), 16'h0000);
        check("rst_load", load, 1'b0);
        rst = 1'b0;
        idle(20);
        check("idle_digits", digits(), 16'h0000);
        check("idle_load", load, 1'b0);

        // sel / inc ignored in IDLE
        tap(3'b001);
        tap(3'b010);
        check("idle_keys_ignored", digits(), 16'h0000);

        // mode, inc x3, sel, inc x12, mode
        tap(3'b100);
        repeat (3) tap(3'b001);
        tap(3'b010);
        repeat (12) tap(3'b001);
        tap(3'b100);
        check("commit_value", digits(), 16'h0312);

        // seconds wrap 58 -> 59 -> 00, minutes untouched
        tap(3'b100);
        tap(3'b010);
        repeat (46) tap(3'b001);
        check("sec_58", digits(), 16'h0358);
        tap(3'b001);
        check("sec_59", digits(), 16'h0359);
        tap(3'b001);
        check("sec_wrap", digits(), 16'h0300);
        tap(3'b100);

        // glitch and held key in EDIT_MIN
        tap(3'b100);
        press(3'b001, 3, 8, fc);
        check("glitch_nochange", fc, 0);
        check("glitch_digits", digits(), 16'h0300);
        press(3'b001, 10, 8, fc);
        check("inc_latency", fc, EV_AT);
        check("held_once", digits(), 16'h0400);

        // mode and inc in the same cycle: commit wins
        press(3'b101, 6, 8, fc);
        check("simul_value", digits(), 16'h0400);

        // blink in EDIT_MIN, then reset mid-edit
        tap(3'b100);
        idle(40);
        rst = 1'b1;
        model_reset();
        idle(2);
        check("rst_mid_digits", digits(), 16'h0000);
        check("rst_mid_load", load, 1'b0);
        rst = 1'b0;
        idle(10);
        check("post_rst_digits", digits(), 16'h0000);

        // key held across reset release yields exactly one event
        tap(3'b100);
        key_mode = 1'b1;
        rst = 1'b1;
        model_reset();
        idle(4);
        rst = 1'b0;
        press(3'b100, 6, 8, fc);
        check("held_rst_editing", editing, 1'b1);

        idle(5);
        check("load_pending", load_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
